sym_fir_serial: RTL and testbench

SYM_FIR_SERIAL -- requirements
Module: sym_fir_serial

---
 rtl/sym_fir_serial.sv | 134 +++++++++++++
 tb/tb_sym_fir_serial.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_fir_serial.sv
// Serial symmetric/antisymmetric FIR: one pre-added tap pair per MAC cycle.
// Define FIR_SAT_EN for rounded, saturated output; default wraps.
module sym_fir_serial #(
  parameter int DIN_W  = 15,
  parameter int COEF_W = 12,
  parameter int TAPS   = 6,
  parameter int SHIFT  = 0,
  parameter int DOUT_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              mode,
  input  logic              coef_we,
  input  logic [4:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid
);

  localparam int NP = TAPS / 2;
  localparam int KW = (NP > 1) ? $clog2(NP) : 1;
  localparam int XW = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam int PW = DIN_W + 1 + COEF_W;
  localparam int AW = PW + $clog2(NP);
  localparam int EW = ((AW > DOUT_W) ? AW : DOUT_W) + 2;
  localparam logic [5:0] NP6 = 6'(NP);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic signed [DIN_W-1:0]  x [TAPS];
  logic signed [COEF_W-1:0] c [NP];
  logic signed [AW-1:0]     acc;
  logic [KW-1:0]            k;
  logic                     mode_q;

  logic accept;
  logic coef_ok;
  logic last;

  assign din_ready = (state == IDLE);
  assign accept    = din_valid && din_ready;
  assign coef_ok   = coef_we && din_ready
                   && ({1'b0, coef_addr} < NP6);
  assign last      = (k == KW'(NP - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Mirror-image taps share one coefficient, so pre-add them.
  logic [XW-1:0]           ia, ib;
  logic signed [DIN_W:0]   xa, xb, pair;
  logic signed [PW-1:0]    prod;

  assign ia   = XW'(k);
  assign ib   = XW'(TAPS - 1) - XW'(k);
  assign xa   = {x[ia][DIN_W-1], x[ia]};
  assign xb   = {x[ib][DIN_W-1], x[ib]};
  assign pair = mode_q ? (xa - xb) : (xa + xb);
  assign prod = PW'(pair) * PW'(c[k]);

  logic signed [EW-1:0] acc_x, shr, res;

  assign acc_x = EW'(acc);

`ifdef FIR_SAT_EN
  localparam logic signed [EW-1:0] RND =
    EW'((64'd1 << SHIFT) >> 1);
  localparam logic signed [EW-1:0] MAXV =
    {{(EW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV =
    {{(EW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  assign shr = (acc_x + RND) >>> SHIFT;
  assign res = (shr > MAXV) ? MAXV
             : (shr < MINV) ? MINV
             : shr;
`else
  assign shr = acc_x >>> SHIFT;
  assign res = shr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      for (int i = 0; i < NP; i++) c[i] <= '0;
      acc        <= '0;
      k          <= '0;
      mode_q     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      coef_err   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      coef_err   <= coef_we && !coef_ok;
      if (coef_ok) c[coef_addr[KW-1:0]] <= coef_data;
      if (accept) begin
        x[0] <= din;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        mode_q <= mode;
        acc    <= '0;
        k      <= '0;
      end else if (state == MAC) begin
        acc <= acc + AW'(prod);
        k   <= k + KW'(1);
      end else if (state == DONE) begin
        dout       <= DOUT_W'(res);
        dout_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sym_fir_serial.sv
// Scoreboard bench for sym_fir_serial: two instances (22-bit and 16-bit out)
// checked against a direct convolution model.
`timescale 1ns/1ps
module tb_sym_fir_serial;

  localparam int DW  = 15;
  localparam int CW  = 12;
  localparam int TP  = 6;
  localparam int NP  = 3;
  localparam int SH  = 0;
  localparam int OW0 = 22;
  localparam int OW1 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]  din [2];
  logic           din_valid [2];
  logic           din_ready [2];
  logic           mode [2];
  logic           coef_we [2];
  logic [4:0]     coef_addr [2];
  logic [CW-1:0]  coef_data [2];
  logic           coef_err [2];
  logic           dout_valid [2];
  logic [OW0-1:0] dout0;
  logic [OW1-1:0] dout1;

  sym_fir_serial #(
    .DIN_W(DW), .COEF_W(CW), .TAPS(TP),
    .SHIFT(SH), .DOUT_W(OW0)
  ) u0 (
    .clk(clk), .rst(rst),
    .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .mode(mode[0]),
    .coef_we(coef_we[0]), .coef_addr(coef_addr[0]),
    .coef_data(coef_data[0]), .coef_err(coef_err[0]),
    .dout(dout0), .dout_valid(dout_valid[0])
  );

  sym_fir_serial #(
    .DIN_W(DW), .COEF_W(CW), .TAPS(TP),
    .SHIFT(SH), .DOUT_W(OW1)
  ) u1 (
    .clk(clk), .rst(rst),
    .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .mode(mode[1]),
    .coef_we(coef_we[1]), .coef_addr(coef_addr[1]),
    .coef_data(coef_data[1]), .coef_err(coef_err[1]),
    .dout(dout1), .dout_valid(dout_valid[1])
  );

  typedef struct {
    longint v;
    int     t;
    bit     hl;
    longint lit;
  } exp_t;

  exp_t   q0[$], q1[$];
  longint lq0[$];
  longint hist [2][TP];
  longint cm [2][NP];
  int     busy [2];
  bit     err_exp [2];
  longint hold [2];
  int     cyc;
  int     checks;
  int     errors;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s act %0d exp %0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint fmt(input longint y, input int w);
    longint r, lo, hi;
    r  = y >>> SH;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
`ifdef FIR_SAT_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    r = r & ((longint'(1) << w) - 1);
    if (r > hi) r = r - (longint'(1) << w);
`endif
    return r;
  endfunction

  function automatic longint msum(input int i, input logic m);
    longint s;
    s = 0;
    for (int j = 0; j < NP; j++) begin
      if (m) s += (hist[i][j] - hist[i][TP-1-j]) * cm[i][j];
      else   s += (hist[i][j] + hist[i][TP-1-j]) * cm[i][j];
    end
    return s;
  endfunction

  function automatic longint dout_of(input int i);
    if (i == 0) return longint'($signed(dout0));
    return longint'($signed(dout1));
  endfunction

  // Reference model: one transaction per accepted sample.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        busy[i]    = 0;
        err_exp[i] = 1'b0;
        hold[i]    = 0;
        for (int j = 0; j < TP; j++) hist[i][j] = 0;
        for (int j = 0; j < NP; j++) cm[i][j] = 0;
      end
      q0.delete();
      q1.delete();
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        err_exp[i] = coef_we[i]
                   && (busy[i] != 0 || coef_addr[i] >= NP);
        if (coef_we[i] && busy[i] == 0 && coef_addr[i] < NP)
          cm[i][coef_addr[i]] = longint'($signed(coef_data[i]));
        if (busy[i] > 0) begin
          busy[i]--;
        end else if (din_valid[i]) begin
          for (int j = TP - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
          hist[i][0] = longint'($signed(din[i]));
          e.v   = fmt(msum(i, mode[i]), (i == 0) ? OW0 : OW1);
          e.t   = cyc + NP + 1;
          e.hl  = 1'b0;
          e.lit = 0;
          if (i == 0 && lq0.size() > 0) begin
            e.hl  = 1'b1;
            e.lit = lq0.pop_front();
          end
          if (i == 0) q0.push_back(e);
          else        q1.push_back(e);
          busy[i] = NP + 1;
        end
      end
    end
  end

  // Monitor: compare DUT outputs against model on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t   e;
      longint d;
      int     qs;
      d = dout_of(i);
      chk(din_ready[i] == (busy[i] == 0),
          $sformatf("ready%0d", i), din_ready[i], busy[i] == 0);
      chk(coef_err[i] == err_exp[i],
          $sformatf("coef_err%0d", i), coef_err[i], err_exp[i]);
      if (dout_valid[i]) begin
        qs = (i == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          chk(1'b0, $sformatf("spurious_valid%0d", i), 1, 0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk(d == e.v, $sformatf("dout%0d", i), d, e.v);
          chk(cyc == e.t, $sformatf("latency%0d", i), cyc, e.t);
          if (e.hl)
            chk(d == e.lit, $sformatf("dout_lit%0d", i), d, e.lit);
          hold[i] = e.v;
        end
      end
      chk(d == hold[i], $sformatf("dout_hold%0d", i), d, hold[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input logic [4:0] a,
                    input logic [CW-1:0] d);
    coef_we[i]   = 1'b1;
    coef_addr[i] = a;
    coef_data[i] = d;
    tick();
    coef_we[i]   = 1'b0;
  endtask

  task automatic send(input int i, input logic [DW-1:0] s,
                      input logic m);
    int n;
    n = 0;
    din[i]       = s;
    mode[i]      = m;
    din_valid[i] = 1'b1;
    while (!din_ready[i] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk(1'b0, "send_timeout", n, 0);
    tick();
    din_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while ((!din_ready[i]
            || ((i == 0) ? q0.size() : q1.size()) != 0)
           && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk(1'b0, "idle_timeout", n, 0);
  endtask

  longint big_exp;

  initial begin
    for (int i = 0; i < 2; i++) begin
      din[i]       = '0;
      din_valid[i] = 1'b0;
      mode[i]      = 1'b0;
      coef_we[i]   = 1'b0;
      coef_addr[i] = '0;
      coef_data[i] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;
    chk(din_ready[0] == 1'b1, "reset_ready", din_ready[0], 1);
    chk(dout_of(0) == 0, "reset_dout", dout_of(0), 0);

    // Impulse response, symmetric then antisymmetric.
    wr(0, 5'd0, 12'd8);
    wr(0, 5'd1, 12'd17);
    wr(0, 5'd2, 12'd11);
    lq0 = '{800, 1700, 1100, 1100, 1700, 800};
    send(0, 15'd100, 1'b0);
    for (int n = 0; n < 5; n++) send(0, 15'd0, 1'b0);
    wait_idle(0);
    lq0 = '{800, 1700, 1100, -1100, -1700, -800};
    send(0, 15'd100, 1'b1);
    for (int n = 0; n < 5; n++) send(0, 15'd0, 1'b1);
    wait_idle(0);

    // Rejected coefficient writes.
    send(0, 15'd55, 1'b0);
    wr(0, 5'd0, 12'd77);
    chk(coef_err[0] == 1'b1, "err_busy", coef_err[0], 1);
    wait_idle(0);
    wr(0, 5'd3, 12'd5);
    chk(coef_err[0] == 1'b1, "err_addr", coef_err[0], 1);
    tick();
    chk(coef_err[0] == 1'b0, "err_pulse", coef_err[0], 0);
    for (int n = 0; n < 6; n++) send(0, 15'd0, 1'b0);
    wait_idle(0);
    lq0 = '{800, 1700, 1100};
    send(0, 15'd100, 1'b0);
    for (int n = 0; n < 5; n++) send(0, 15'd0, 1'b0);
    wait_idle(0);

    // Full-scale input into the 16-bit output instance.
    for (int a = 0; a < NP; a++) wr(1, 5'(a), 12'd2047);
    for (int n = 0; n < 6; n++) send(1, 15'd16383, 1'b0);
    wait_idle(1);
`ifdef FIR_SAT_EN
    big_exp = 32767;
`else
    big_exp = 20486;
`endif
    chk(dout_of(1) == big_exp, "full_scale", dout_of(1), big_exp);

    // Reset during the second MAC cycle.
    send(0, 15'd1234, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(din_ready[0] == 1'b1, "rst_ready", din_ready[0], 1);
    chk(dout_of(0) == 0, "rst_dout", dout_of(0), 0);
    tick();
    chk(din_ready[0] == 1'b1, "rst_ready2", din_ready[0], 1);
    repeat (8) tick();

    // Random samples, gaps, modes and coefficient writes.
    for (int a = 0; a < NP; a++) wr(0, 5'(a), CW'($urandom));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        wr(0, 5'($urandom_range(0, 4)), CW'($urandom));
      send(0, DW'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle(0);

    // din_valid held high; inputs churn while busy.
    din_valid[0] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      din[0]       = DW'($urandom);
      mode[0]      = 1'($urandom);
      coef_we[0]   = ($urandom_range(0, 7) == 0);
      coef_addr[0] = 5'($urandom_range(0, 3));
      coef_data[0] = CW'($urandom);
      tick();
    end
    din_valid[0] = 1'b0;
    coef_we[0]   = 1'b0;
    repeat (10) tick();
    chk(q0.size() == 0, "drain0", q0.size(), 0);
    chk(q1.size() == 0, "drain1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act 1 exp 0");
    $fatal(1, "watchdog");
  end

endmodule
